// File: rtl/xi_ext_mem_responder_if.sv
// Bundle between xi_multicore_top's ext_* side, the host bridge and the node-memory responder.
// The master drives requests and err_clr; the slave returns data, readiness, error flags and statistics.
interface xi_ext_mem_responder_if #(
   parameter int ADDR_W = 16,
   parameter int NODE_W = 160
);
   logic              ext_rd_en;
   logic [ADDR_W-1:0] ext_rd_addr;
   logic [NODE_W-1:0] ext_rd_data;
   logic              ext_rd_valid;
   logic              ext_wr_en;
   logic [ADDR_W-1:0] ext_wr_addr;
   logic [NODE_W-1:0] ext_wr_data;

   logic              host_wr_en;
   logic [ADDR_W-1:0] host_wr_addr;
   logic [NODE_W-1:0] host_wr_data;
   logic              host_wr_ready;
   logic              host_rd_en;
   logic [ADDR_W-1:0] host_rd_addr;
   logic              host_rd_ready;
   logic [NODE_W-1:0] host_rd_data;
   logic              host_rd_valid;

   logic              err_clr;
   logic              err_rd_oob;
   logic              err_wr_oob;
   logic [31:0]       stat_rd_count;
   logic [31:0]       stat_wr_count;
   logic [31:0]       stat_host_stalls;

   modport master (
      output ext_rd_en, ext_rd_addr, ext_wr_en, ext_wr_addr, ext_wr_data,
      output host_wr_en, host_wr_addr, host_wr_data, host_rd_en, host_rd_addr,
      output err_clr,
      input  ext_rd_data, ext_rd_valid, host_wr_ready, host_rd_ready,
      input  host_rd_data, host_rd_valid, err_rd_oob, err_wr_oob,
      input  stat_rd_count, stat_wr_count, stat_host_stalls
   );

   modport slave (
      input  ext_rd_en, ext_rd_addr, ext_wr_en, ext_wr_addr, ext_wr_data,
      input  host_wr_en, host_wr_addr, host_wr_data, host_rd_en, host_rd_addr,
      input  err_clr,
      output ext_rd_data, ext_rd_valid, host_wr_ready, host_rd_ready,
      output host_rd_data, host_rd_valid, err_rd_oob, err_wr_oob,
      output stat_rd_count, stat_wr_count, stat_host_stalls
   );
endinterface

// File: rtl/xi_ext_mem_responder.sv
// Node-memory responder: fixed-latency 160-bit reads and single-cycle writes from an on-chip array,
// shared between the core (priority) and a host port, with sticky OOB flags and saturating statistics.
module xi_ext_mem_responder #(
   parameter int ADDR_W     = 16,
   parameter int MEM_DEPTH  = 4096,
   parameter int NODE_W     = 160,
   parameter int RD_LATENCY = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   xi_ext_mem_responder_if.slave bus
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_A = MEM_DEPTH[ADDR_W:0];

   generate
      if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
         $error("xi_ext_mem_responder: RD_LATENCY must be in 1..4");
      end
      if (IDX_W > ADDR_W) begin : g_bad_depth
         $error("xi_ext_mem_responder: MEM_DEPTH does not fit in ADDR_W");
      end
   endgenerate

   logic [NODE_W-1:0] mem_q [MEM_DEPTH];

   // ---------------- request arbitration ----------------
   logic              rd_go;
   logic              rd_src;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_oob;
   logic              rd_do;
   logic              wr_go;
   logic [ADDR_W-1:0] wr_addr;
   logic [NODE_W-1:0] wr_data;
   logic              wr_oob;
   logic              wr_do;

   always_comb begin
      rd_go   = bus.ext_rd_en | bus.host_rd_en;
      rd_src  = ~bus.ext_rd_en;
      rd_addr = bus.ext_rd_en ? bus.ext_rd_addr : bus.host_rd_addr;
      rd_oob  = rd_go && ({1'b0, rd_addr} >= DEPTH_A);
      rd_do   = rd_go && !rd_oob;

      wr_go   = bus.ext_wr_en | bus.host_wr_en;
      wr_addr = bus.ext_wr_en ? bus.ext_wr_addr : bus.host_wr_addr;
      wr_data = bus.ext_wr_en ? bus.ext_wr_data : bus.host_wr_data;
      wr_oob  = wr_go && ({1'b0, wr_addr} >= DEPTH_A);
      wr_do   = wr_go && !wr_oob;
   end

   assign bus.host_wr_ready = ~bus.ext_wr_en;
   assign bus.host_rd_ready = ~bus.ext_rd_en;

   // ---------------- memory array ----------------
   logic [NODE_W-1:0] rd_word_q;

   always_ff @(posedge clk) begin
      if (wr_do) begin
         mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

   // Registered read sees the pre-write contents, giving read-before-write on same-address collisions.
   always_ff @(posedge clk) begin
      if (rd_do) begin
         rd_word_q <= mem_q[rd_addr[IDX_W-1:0]];
      end
   end

   // ---------------- return pipeline ----------------
   logic vld0_q;
   logic src0_q;
   logic oob0_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld0_q <= 1'b0;
         src0_q <= 1'b0;
         oob0_q <= 1'b0;
      end else begin
         vld0_q <= rd_go;
         src0_q <= rd_src;
         oob0_q <= rd_oob;
      end
   end

   logic [NODE_W-1:0]     chain_data [RD_LATENCY];
   logic [RD_LATENCY-1:0] chain_vld;
   logic [RD_LATENCY-1:0] chain_src;

   assign chain_data[0] = oob0_q ? '0 : rd_word_q;
   assign chain_vld[0]  = vld0_q;
   assign chain_src[0]  = src0_q;

   genvar gi;
   generate
      for (gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
         logic              vld_q;
         logic              src_q;
         logic [NODE_W-1:0] data_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_q  <= 1'b0;
               src_q  <= 1'b0;
               data_q <= '0;
            end else begin
               vld_q <= chain_vld[gi-1];
               src_q <= chain_src[gi-1];
               if (chain_vld[gi-1]) begin
                  data_q <= chain_data[gi-1];
               end
            end
         end

         assign chain_vld[gi]  = vld_q;
         assign chain_src[gi]  = src_q;
         assign chain_data[gi] = data_q;
      end
   endgenerate

   logic              out_ext;
   logic              out_host;
   logic [NODE_W-1:0] out_data;
   logic [NODE_W-1:0] ext_hold_q;
   logic [NODE_W-1:0] host_hold_q;

   assign out_ext  = chain_vld[RD_LATENCY-1] & ~chain_src[RD_LATENCY-1];
   assign out_host = chain_vld[RD_LATENCY-1] &  chain_src[RD_LATENCY-1];
   assign out_data = chain_data[RD_LATENCY-1];

   // Hold registers keep the last returned word visible while valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_hold_q  <= '0;
         host_hold_q <= '0;
      end else begin
         if (out_ext) begin
            ext_hold_q <= out_data;
         end
         if (out_host) begin
            host_hold_q <= out_data;
         end
      end
   end

   assign bus.ext_rd_valid  = out_ext;
   assign bus.host_rd_valid = out_host;
   assign bus.ext_rd_data   = out_ext  ? out_data : ext_hold_q;
   assign bus.host_rd_data  = out_host ? out_data : host_hold_q;

   // ---------------- error flags and statistics ----------------
   logic        err_rd_oob_q;
   logic        err_rd_oob_d;
   logic        err_wr_oob_q;
   logic        err_wr_oob_d;
   logic [31:0] stat_rd_q;
   logic [31:0] stat_rd_d;
   logic [31:0] stat_wr_q;
   logic [31:0] stat_wr_d;
   logic [31:0] stat_stall_q;
   logic [31:0] stat_stall_d;
   logic        host_stall;

   always_comb begin
      host_stall = (bus.host_wr_en & bus.ext_wr_en) | (bus.host_rd_en & bus.ext_rd_en);

      // A new OOB event overrides a simultaneous clear.
      err_rd_oob_d = err_rd_oob_q;
      if (bus.err_clr) err_rd_oob_d = 1'b0;
      if (rd_oob)      err_rd_oob_d = 1'b1;

      err_wr_oob_d = err_wr_oob_q;
      if (bus.err_clr) err_wr_oob_d = 1'b0;
      if (wr_oob)      err_wr_oob_d = 1'b1;

      stat_rd_d = stat_rd_q;
      if (bus.ext_rd_en && (stat_rd_q != '1)) stat_rd_d = stat_rd_q + 32'd1;

      stat_wr_d = stat_wr_q;
      if (bus.ext_wr_en && (stat_wr_q != '1)) stat_wr_d = stat_wr_q + 32'd1;

      stat_stall_d = stat_stall_q;
      if (host_stall && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_rd_oob_q <= 1'b0;
         err_wr_oob_q <= 1'b0;
         stat_rd_q    <= '0;
         stat_wr_q    <= '0;
         stat_stall_q <= '0;
      end else begin
         err_rd_oob_q <= err_rd_oob_d;
         err_wr_oob_q <= err_wr_oob_d;
         stat_rd_q    <= stat_rd_d;
         stat_wr_q    <= stat_wr_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign bus.err_rd_oob       = err_rd_oob_q;
   assign bus.err_wr_oob       = err_wr_oob_q;
   assign bus.stat_rd_count    = stat_rd_q;
   assign bus.stat_wr_count    = stat_wr_q;
   assign bus.stat_host_stalls = stat_stall_q;

endmodule

// File: tb/tb_xi_ext_mem_responder.sv
// Scoreboard bench for xi_ext_mem_responder at RD_LATENCY=3: stimulus pushes expected returns,
// a negedge monitor pops and compares each valid pulse including its arrival cycle.
module tb_xi_ext_mem_responder;
   localparam int AW    = 16;
   localparam int NW    = 160;
   localparam int DEPTH = 4096;
   localparam int LAT   = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xi_ext_mem_responder_if #(.ADDR_W(AW), .NODE_W(NW)) bus ();

   xi_ext_mem_responder #(
      .ADDR_W(AW), .MEM_DEPTH(DEPTH), .NODE_W(NW), .RD_LATENCY(LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          host;
      logic [NW-1:0] data;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   logic [NW-1:0] node [4];
   logic [NW-1:0] val_a, val_b, val_h, val_e1, val_e2, val_v, val_w;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse must match the head of the scoreboard in source, data and cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ext_rd_valid || bus.host_rd_valid) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_valid: got ext=%0b host=%0b at cycle %0d, required none",
                        bus.ext_rd_valid, bus.host_rd_valid, cyc);
            end else begin
               mon_e = sb_q.pop_front();
               $display("[TB] rd return host=%0b cyc=%0d data=%h", mon_e.host, cyc,
                        mon_e.host ? bus.host_rd_data : bus.ext_rd_data);
               check("rd_src", {bus.host_rd_valid, bus.ext_rd_valid}, {mon_e.host, ~mon_e.host});
               check("rd_data", mon_e.host ? bus.host_rd_data : bus.ext_rd_data, mon_e.data);
               check("rd_cycle", NW'(cyc), NW'(mon_e.cyc));
            end
         end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            mon_e = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_valid: got no pulse by cycle %0d, required at cycle %0d", cyc, mon_e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.ext_rd_en   = 1'b0; bus.ext_rd_addr  = '0;
      bus.ext_wr_en   = 1'b0; bus.ext_wr_addr  = '0; bus.ext_wr_data  = '0;
      bus.host_wr_en  = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
      bus.host_rd_en  = 1'b0; bus.host_rd_addr = '0;
      bus.err_clr     = 1'b0;
   endtask

   task automatic expect_rd(input bit host, input logic [NW-1:0] d);
      exp_t e;
      e.host = host;
      e.data = d;
      e.cyc  = cyc + LAT;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < LAT + 4 && sb_q.size() > 0; i++) step();
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ext_valid"},  NW'(bus.ext_rd_valid), '0);
      check({tag, "_host_valid"}, NW'(bus.host_rd_valid), '0);
      check({tag, "_ext_data"},   bus.ext_rd_data, '0);
      check({tag, "_host_data"},  bus.host_rd_data, '0);
      check({tag, "_errs"},       NW'({bus.err_rd_oob, bus.err_wr_oob}), '0);
      check({tag, "_stat_rd"},    NW'(bus.stat_rd_count), '0);
      check({tag, "_stat_wr"},    NW'(bus.stat_wr_count), '0);
      check({tag, "_stat_stall"}, NW'(bus.stat_host_stalls), '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      node[0] = {4'h1, 4'd2, 4'd3, 4'd4, 16'd1, 16'd2, 16'd3, 16'd4, 80'h0};
      node[1] = {4'h1, 4'd0, 4'd0, 4'd0, 16'd3, 16'd0, 16'd0, 16'd0, 80'h0};
      node[2] = {4'h2, 92'd0, 64'd42};
      node[3] = {4'h2, 92'd0, 64'd7};
      val_a  = {32'hAAAA_0001, 128'h0};
      val_b  = {96'h0, 64'hBBBB_0002};
      val_h  = {4'h2, 92'd0, 64'd99};
      val_e1 = {160{1'b1}};
      val_e2 = {80'h0, 80'h1234_5678_9ABC_DEF0_1357};
      val_v  = {40'hCAFE_F00D_11, 120'h0};
      val_w  = {160{1'b1}};

      idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      // Host loads nodes 0..3 with the core idle.
      for (int i = 0; i < 4; i++) begin
         bus.host_wr_en   = 1'b1;
         bus.host_wr_addr = AW'(i);
         bus.host_wr_data = node[i];
         #1;
         check("host_wr_ready_idle", NW'(bus.host_wr_ready), NW'(1));
         $display("[TB] host write addr=%0d", i);
         step();
      end
      idle();

      bus.host_rd_en   = 1'b1;
      bus.host_rd_addr = 16'd2;
      expect_rd(1'b1, node[2]);
      step();
      idle();
      drain();
      check("host_rd_low64", NW'(bus.host_rd_data[63:0]), NW'(42));

      // Four back-to-back core reads.
      for (int i = 0; i < 4; i++) begin
         bus.ext_rd_en   = 1'b1;
         bus.ext_rd_addr = AW'(i);
         expect_rd(1'b0, node[i]);
         step();
      end
      idle();
      drain();
      check("stat_rd_burst", NW'(bus.stat_rd_count), NW'(4));
      check("ext_data_hold", bus.ext_rd_data, node[3]);

      // Read-before-write on the same address.
      bus.ext_wr_en = 1'b1; bus.ext_wr_addr = 16'd5; bus.ext_wr_data = val_b;
      step();
      bus.ext_wr_data = val_a;
      bus.ext_rd_en = 1'b1; bus.ext_rd_addr = 16'd5;
      expect_rd(1'b0, val_b);
      step();
      bus.ext_wr_en = 1'b0;
      expect_rd(1'b0, val_a);
      step();
      idle();
      drain();
      check("stat_wr_rbw", NW'(bus.stat_wr_count), NW'(2));

      // Host write held three cycles, core writes on the first two.
      bus.host_wr_en = 1'b1; bus.host_wr_addr = 16'd6; bus.host_wr_data = val_h;
      bus.ext_wr_en  = 1'b1; bus.ext_wr_addr  = 16'd7; bus.ext_wr_data  = val_e1;
      #1;
      check("host_wr_ready_c1", NW'(bus.host_wr_ready), NW'(0));
      step();
      bus.ext_wr_data = val_e2;
      #1;
      check("host_wr_ready_c2", NW'(bus.host_wr_ready), NW'(0));
      step();
      bus.ext_wr_en = 1'b0;
      #1;
      check("host_wr_ready_c3", NW'(bus.host_wr_ready), NW'(1));
      step();
      idle();
      check("stat_stalls_wr", NW'(bus.stat_host_stalls), NW'(2));
      bus.ext_rd_en = 1'b1; bus.ext_rd_addr = 16'd6;
      expect_rd(1'b0, val_h);
      step();
      bus.ext_rd_addr = 16'd7;
      expect_rd(1'b0, val_e2);
      step();
      idle();
      drain();

      // Host read stalled by a core read, accepted the next cycle.
      bus.ext_rd_en  = 1'b1; bus.ext_rd_addr  = 16'd0;
      bus.host_rd_en = 1'b1; bus.host_rd_addr = 16'd1;
      #1;
      check("host_rd_ready_busy", NW'(bus.host_rd_ready), NW'(0));
      expect_rd(1'b0, node[0]);
      step();
      bus.ext_rd_en = 1'b0;
      #1;
      check("host_rd_ready_free", NW'(bus.host_rd_ready), NW'(1));
      expect_rd(1'b1, node[1]);
      step();
      idle();
      drain();
      check("stat_stalls_rd", NW'(bus.stat_host_stalls), NW'(3));

      // Out-of-range accesses and error flags.
      bus.ext_wr_en = 1'b1; bus.ext_wr_addr = 16'd4095; bus.ext_wr_data = val_v;
      step();
      idle();
      bus.ext_rd_en = 1'b1; bus.ext_rd_addr = 16'd4096;
      expect_rd(1'b0, '0);
      step();
      idle();
      check("err_rd_oob_set", NW'(bus.err_rd_oob), NW'(1));
      check("err_wr_oob_clear", NW'(bus.err_wr_oob), NW'(0));
      drain();
      bus.host_wr_en = 1'b1; bus.host_wr_addr = 16'hFFFF; bus.host_wr_data = val_w;
      step();
      idle();
      check("err_wr_oob_set", NW'(bus.err_wr_oob), NW'(1));
      bus.ext_rd_en = 1'b1; bus.ext_rd_addr = 16'd4095;
      expect_rd(1'b0, val_v);
      step();
      idle();
      drain();
      bus.err_clr = 1'b1;
      bus.host_rd_en = 1'b1; bus.host_rd_addr = 16'd5000;
      expect_rd(1'b1, '0);
      step();
      idle();
      check("err_set_wins", NW'({bus.err_rd_oob, bus.err_wr_oob}), NW'(2'b10));
      bus.err_clr = 1'b1;
      step();
      idle();
      check("err_clr_both", NW'({bus.err_rd_oob, bus.err_wr_oob}), NW'(2'b00));
      drain();
      check("stat_wr_total", NW'(bus.stat_wr_count), NW'(5));

      // Reset with two reads in flight.
      bus.ext_rd_en = 1'b1; bus.ext_rd_addr = 16'd0;
      step();
      bus.ext_rd_addr = 16'd1;
      step();
      idle();
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check_reset_outputs("inflight_rst");
      repeat (2) step();
      rst_n = 1'b1;
      repeat (LAT + 4) step();
      check("post_rst_ext_data", bus.ext_rd_data, '0);
      bus.ext_rd_en = 1'b1; bus.ext_rd_addr = 16'd2;
      expect_rd(1'b0, node[2]);
      step();
      idle();
      drain();

      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %0d pending, required 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
